// File: rtl/tdc_readout_arbiter.sv
// Round-robin readout arbiter for a bank of TDC channels: capture, present, clear, drain.
// Optional event counter output o_eventCount when TDC_ARB_STATS_EN is defined.
module tdc_readout_arbiter #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned CHAN_ID_W    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CHANNELS-1:0]      i_enable_mask,
   input  logic [NUM_CHANNELS-1:0]      i_hasEvent,
   input  logic [NUM_CHANNELS-1:0]      i_busy,
   input  logic [32*NUM_CHANNELS-1:0]   i_timestamp,
   input  logic [32*NUM_CHANNELS-1:0]   i_pulseWidth,
   output logic [NUM_CHANNELS-1:0]      o_enable_channel,
   output logic [NUM_CHANNELS-1:0]      o_clear,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [CHAN_ID_W-1:0]         o_channel,
   output logic [31:0]                  o_timestamp,
   output logic [31:0]                  o_pulseWidth,
`ifdef TDC_ARB_STATS_EN
   output logic [31:0]                  o_eventCount,
`endif
   output logic                         o_busy
);

   typedef enum logic [1:0] {StIdle, StCapture, StPresent, StDrain} state_t;

   state_t                    r_state;
   logic [NUM_CHANNELS-1:0]   r_enable;
   logic [NUM_CHANNELS-1:0]   r_clear;
   logic [CHAN_ID_W-1:0]      r_ptr;
   logic [CHAN_ID_W-1:0]      r_grant;
   logic [CHAN_ID_W-1:0]      r_channel;
   logic [31:0]               r_ts;
   logic [31:0]               r_tot;
   logic                      r_valid;
   logic                      r_busy;

   logic [NUM_CHANNELS-1:0]   w_req;
   logic                      w_any;
   logic [CHAN_ID_W-1:0]      w_gnt;
   logic [NUM_CHANNELS-1:0]   w_gnt_onehot;
   logic [CHAN_ID_W-1:0]      w_ptr_next;
   logic [31:0]               w_ts_sel;
   logic [31:0]               w_tot_sel;
   logic                      w_drain_done;
   logic                      w_unused;

   // Channel busy flags are status only; they never influence arbitration.
   assign w_unused = ^i_busy;

   assign w_req = i_hasEvent & r_enable;

   // First requesting channel at or after the pointer, wrapping around the bank.
   always_comb begin
      int unsigned v_idx;
      v_idx = 0;
      w_any = 1'b0;
      w_gnt = '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         v_idx = (32'(r_ptr) + i) % NUM_CHANNELS;
         if (!w_any && w_req[CHAN_ID_W'(v_idx)]) begin
            w_any = 1'b1;
            w_gnt = CHAN_ID_W'(v_idx);
         end
      end
   end

   always_comb begin
      w_gnt_onehot          = '0;
      w_gnt_onehot[r_grant] = 1'b1;
   end

   assign w_ptr_next   = (r_grant == CHAN_ID_W'(NUM_CHANNELS - 1)) ? '0 : r_grant + 1'b1;
   assign w_ts_sel     = i_timestamp[32*32'(r_grant) +: 32];
   assign w_tot_sel    = i_pulseWidth[32*32'(r_grant) +: 32];
   // Drain also ends when the channel is disabled, so a masked channel cannot wedge us.
   assign w_drain_done = !i_hasEvent[r_grant] || !r_enable[r_grant];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_enable  <= '0;
         r_clear   <= '0;
         r_ptr     <= '0;
         r_grant   <= '0;
         r_channel <= '0;
         r_ts      <= '0;
         r_tot     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_enable <= i_enable_mask;
         r_clear  <= '0;
         case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_grant <= w_gnt;
                  r_busy  <= 1'b1;
                  r_state <= StCapture;
               end
            end
            StCapture: begin
               r_channel <= r_grant;
               r_ts      <= w_ts_sel;
               r_tot     <= w_tot_sel;
               r_valid   <= 1'b1;
               r_state   <= StPresent;
            end
            StPresent: begin
               if (i_ready) begin
                  r_valid <= 1'b0;
                  r_clear <= w_gnt_onehot;
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if (w_drain_done) begin
                  r_ptr   <= w_ptr_next;
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef TDC_ARB_STATS_EN
   logic [31:0] r_event_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_event_count <= '0;
      end else if (r_valid && i_ready) begin
         r_event_count <= r_event_count + 32'd1;
      end
   end

   assign o_eventCount = r_event_count;
`endif

   assign o_enable_channel = r_enable;
   assign o_clear          = r_clear;
   assign o_valid          = r_valid;
   assign o_channel        = r_channel;
   assign o_timestamp      = r_ts;
   assign o_pulseWidth     = r_tot;
   assign o_busy           = r_busy;

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Scoreboard bench for tdc_readout_arbiter: directed scenarios plus randomized rounds.
// Covers o_eventCount when TDC_ARB_STATS_EN is defined.
module tb_tdc_readout_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      i_enable_mask = '0;
   logic [N-1:0]      i_hasEvent = '0;
   logic [N-1:0]      i_busy = '0;
   logic [32*N-1:0]   i_timestamp = '0;
   logic [32*N-1:0]   i_pulseWidth = '0;
   logic [N-1:0]      o_enable_channel;
   logic [N-1:0]      o_clear;
   logic              o_valid;
   logic              i_ready = 1'b0;
   logic [IW-1:0]     o_channel;
   logic [31:0]       o_timestamp;
   logic [31:0]       o_pulseWidth;
   logic              o_busy;
`ifdef TDC_ARB_STATS_EN
   logic [31:0]       o_eventCount;
`endif

   tdc_readout_arbiter #(.NUM_CHANNELS(N), .CHAN_ID_W(IW)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_enable_mask    (i_enable_mask),
      .i_hasEvent       (i_hasEvent),
      .i_busy           (i_busy),
      .i_timestamp      (i_timestamp),
      .i_pulseWidth     (i_pulseWidth),
      .o_enable_channel (o_enable_channel),
      .o_clear          (o_clear),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_channel        (o_channel),
      .o_timestamp      (o_timestamp),
      .o_pulseWidth     (o_pulseWidth),
`ifdef TDC_ARB_STATS_EN
      .o_eventCount     (o_eventCount),
`endif
      .o_busy           (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IW-1:0] ch;
      logic [31:0]   ts;
      logic [31:0]   tot;
   } word_t;

   word_t        sb[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           ptr_m = 0;
   int           ready_mode = 1;   // 0 random, 1 always high, 2 always low
   logic [N-1:0] hold = '0;        // channels whose TDC ignores clear
   int           hs_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a batch of simultaneous requests is served in cyclic order from the pointer.
   task automatic push_round(input logic [N-1:0] bits);
      int last;
      int k;
      last = -1;
      for (int i = 0; i < N; i++) begin
         k = (ptr_m + i) % N;
         if (bits[IW'(k)]) begin
            sb.push_back('{ch: IW'(k), ts: i_timestamp[32*k +: 32], tot: i_pulseWidth[32*k +: 32]});
            last = k;
         end
      end
      if (last >= 0) ptr_m = (last + 1) % N;
   endtask

   task automatic set_data(input int k, input logic [31:0] ts, input logic [31:0] tot);
      i_timestamp[32*k +: 32]  = ts;
      i_pulseWidth[32*k +: 32] = tot;
   endtask

   task automatic set_mask(input logic [N-1:0] m);
      @(negedge clk);
      i_enable_mask = m;
      @(posedge clk);
      #1;
      check("enable_reg", 64'(o_enable_channel), 64'(m));
   endtask

   task automatic raise(input logic [N-1:0] bits, input bit rnd);
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         if (rnd && bits[IW'(k)]) set_data(k, $urandom, $urandom);
      end
      push_round(bits & i_enable_mask);
      i_hasEvent = i_hasEvent | bits;
   endtask

   task automatic wait_round();
      int t;
      t = 0;
      while ((sb.size() != 0 || o_busy || (i_hasEvent & i_enable_mask & ~hold) != '0) && t < 600)
      begin
         @(negedge clk);
         t++;
      end
      check("round_done", 64'(t < 600), 64'd1);
   endtask

   task automatic wait_valid(input string name);
      int t;
      t = 0;
      while (!o_valid && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      check(name, 64'(o_valid), 64'd1);
   endtask

   // Monitor: drives ready, pops the scoreboard on each handshake, checks clear and stability.
   initial begin
      logic         pend;
      logic [IW-1:0] pend_ch;
      logic         pv;
      logic [N-1:0] oh;
      word_t        prev;
      word_t        w;
      pend = 1'b0;
      pend_ch = '0;
      pv = 1'b0;
      prev = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pend) begin
            oh = '0;
            oh[pend_ch] = 1'b1;
            check("clear_pulse", 64'(o_clear), 64'(oh));
            check("valid_drop", 64'(o_valid), 64'd0);
            pend = 1'b0;
         end else begin
            check("clear_idle", 64'(o_clear), 64'd0);
         end
         if (pv && o_valid)
            check("hold_stable", 64'({o_channel, o_timestamp, o_pulseWidth}), 64'(prev));
         case (ready_mode)
            0:       i_ready = 1'($urandom_range(0, 1));
            1:       i_ready = 1'b1;
            default: i_ready = 1'b0;
         endcase
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got ch %0d ts %0h, none expected", o_channel,
                        o_timestamp);
            end else begin
               w = sb.pop_front();
               check("word_ch", 64'(o_channel), 64'(w.ch));
               check("word_ts", 64'(o_timestamp), 64'(w.ts));
               check("word_tot", 64'(o_pulseWidth), 64'(w.tot));
            end
            pend = 1'b1;
            pend_ch = o_channel;
            hs_count++;
         end
         pv = o_valid && !i_ready;
         prev = '{ch: o_channel, ts: o_timestamp, tot: o_pulseWidth};
      end
   end

   // TDC model: a cleared channel drops its event flag after 0..3 cycles.
   initial begin
      int cnt[N];
      for (int k = 0; k < N; k++) cnt[k] = -1;
      forever begin
         @(posedge clk);
         #2;
         for (int k = 0; k < N; k++) begin
            if (o_clear[IW'(k)] && !hold[IW'(k)]) cnt[k] = $urandom_range(0, 3);
            if (cnt[k] == 0) begin
               i_hasEvent[IW'(k)] = 1'b0;
               cnt[k] = -1;
            end else if (cnt[k] > 0) begin
               cnt[k]--;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int t;
      #2;
      reset = 1'b0;
      i_enable_mask = '1;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_clear", 64'(o_clear), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_enable", 64'(o_enable_channel), 64'd0);
      check("rst_data", 64'({o_channel, o_timestamp, o_pulseWidth}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("enable_after_rst", 64'(o_enable_channel), 64'hF);

      // Round robin from pointer 0, then a re-raised channel 0.
      ready_mode = 1;
      set_mask(4'b1111);
      raise(4'b1111, 1'b1);
      wait_round();
      raise(4'b0001, 1'b1);
      wait_round();

      // Single event with fixed data and latency measurement.
      set_mask(4'b0001);
      @(negedge clk);
      set_data(0, 32'h0000_1234, 32'h0000_0010);
      raise(4'b0001, 1'b0);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!o_valid && lat < 10);
      check("latency", 64'(lat), 64'd2);
      wait_round();
      check("busy_idle", 64'(o_busy), 64'd0);

      // Backpressure on channel 2 for 10 cycles.
      set_mask(4'b1111);
      ready_mode = 2;
      raise(4'b0100, 1'b1);
      wait_valid("bp_valid");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", 64'(o_valid), 64'd1);
      end
      ready_mode = 1;
      wait_round();

      // Masked channel 3 must never be served or cleared.
      set_mask(4'b0010);
      raise(4'b1010, 1'b1);
      wait_round();
      repeat (5) @(negedge clk);
      check("masked_pending", 64'(i_hasEvent[3]), 64'd1);
      check("masked_idle", 64'(o_busy), 64'd0);
      i_hasEvent = '0;

      // Mask dropped while the word is presented; drain must not wait for the flag.
      set_mask(4'b0001);
      hold = 4'b0001;
      ready_mode = 2;
      raise(4'b0001, 1'b1);
      wait_valid("mdrop_valid");
      @(negedge clk);
      i_enable_mask = '0;
      ready_mode = 1;
      t = 0;
      while ((o_busy || sb.size() != 0) && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("mdrop_exit", 64'(o_busy), 64'd0);
      check("mdrop_flag_held", 64'(i_hasEvent[0]), 64'd1);
      @(negedge clk);
      hold = '0;
      i_hasEvent = '0;

      // Async reset while presenting channel 3; afterwards channel 0 wins.
      set_mask(4'b1111);
      ready_mode = 2;
      raise(4'b1001, 1'b1);
      wait_valid("rp_valid");
      check("rp_first_ch", 64'(o_channel), 64'(ptr_m == 1 ? 3 : 0));
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rp_valid", 64'(o_valid), 64'd0);
      check("rp_clear", 64'(o_clear), 64'd0);
      check("rp_busy", 64'(o_busy), 64'd0);
      sb.delete();
      ptr_m = 0;
      hs_count = 0;
      @(negedge clk);
      reset = 1'b1;
      push_round(i_hasEvent & i_enable_mask);
      ready_mode = 1;
      wait_round();

      // Randomized rounds with random ready.
      for (int r = 0; r < 150; r++) begin
         ready_mode = (r % 3 == 0) ? 1 : 0;
         set_mask(4'($urandom));
         raise(4'($urandom), 1'b1);
         wait_round();
         @(negedge clk);
         i_hasEvent = '0;
      end
      ready_mode = 1;

`ifdef TDC_ARB_STATS_EN
      repeat (2) @(negedge clk);
      check("event_count", 64'(o_eventCount), 64'(hs_count));
      force dut.r_event_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_event_count;
      set_mask(4'b0001);
      raise(4'b0001, 1'b1);
      wait_round();
      check("event_wrap", 64'(o_eventCount), 64'd0);
`endif

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
